// File: rtl/h_bdy_fe_sched.sv
// rtl/h_bdy_fe_sched.sv - front-end command scheduler: credits, lockstep queue pop, back-end issue slot, flush/drain
// Optional operand-lag/credit checker enabled by defining H_BDY_FE_SCHED_CHECK_EN.

package cfg_pkg;
    parameter int CMD_QUEUE_N = 8;
    parameter int K_W         = 16;
    parameter int V_W         = 32;
    parameter int H_W         = 8;
endpackage

package h_pkg;
    parameter int OPCODE_W = 4;
    parameter logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    parameter logic [OPCODE_W-1:0] OP_GET  = 4'h1;
    parameter logic [OPCODE_W-1:0] OP_PUT  = 4'h2;
    parameter logic [OPCODE_W-1:0] OP_DEL  = 4'h3;
    parameter logic [OPCODE_W-1:0] OP_SETK = 4'h4;
    parameter logic [OPCODE_W-1:0] OP_WRV  = 4'h5;
endpackage

module h_bdy_fe_dec (
    input  logic [h_pkg::OPCODE_W-1:0] op_i,
    output logic                       has_k_o,
    output logic                       has_v_o,
    output logic                       has_hash_o
);
    always_comb begin
        has_k_o    = 1'b0;
        has_v_o    = 1'b0;
        has_hash_o = 1'b0;
        case (op_i)
            h_pkg::OP_GET:  begin has_k_o = 1'b1; has_hash_o = 1'b1; end
            h_pkg::OP_PUT:  begin has_k_o = 1'b1; has_v_o = 1'b1; has_hash_o = 1'b1; end
            h_pkg::OP_DEL:  begin has_k_o = 1'b1; has_hash_o = 1'b1; end
            h_pkg::OP_SETK: has_k_o = 1'b1;
            h_pkg::OP_WRV:  has_v_o = 1'b1;
            default: ;
        endcase
    end
endmodule

module h_bdy_fe_sched #(
    parameter int N     = cfg_pkg::CMD_QUEUE_N,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        i_cmd_vld_w,
    output logic                        o_cmd_rdy_w,
    input  logic                        i_q_op_empty,
    input  logic [h_pkg::OPCODE_W-1:0]  i_q_op_dat,
    output logic                        o_q_op_pop,
    input  logic                        i_q_k_empty,
    input  logic [cfg_pkg::K_W-1:0]     i_q_k_dat,
    output logic                        o_q_k_pop,
    input  logic                        i_q_v_empty,
    input  logic [cfg_pkg::V_W-1:0]     i_q_v_dat,
    output logic                        o_q_v_pop,
    input  logic                        i_q_h_empty,
    input  logic [cfg_pkg::H_W-1:0]     i_q_h_dat,
    output logic                        o_q_h_pop,
    output logic                        o_bdy_vld_r,
    output logic [h_pkg::OPCODE_W-1:0]  o_bdy_opcode_r,
    output logic [cfg_pkg::K_W-1:0]     o_bdy_k_r,
    output logic [cfg_pkg::V_W-1:0]     o_bdy_v_r,
    output logic [cfg_pkg::H_W-1:0]     o_bdy_h_r,
    input  logic                        i_bdy_rdy,
    input  logic                        i_flush_req,
`ifdef H_BDY_FE_SCHED_CHECK_EN
    output logic                        o_flush_done_r,
    output logic                        o_err_r
`else
    output logic                        o_flush_done_r
`endif
);
    localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        vld_q, vld_d;
    logic [h_pkg::OPCODE_W-1:0]  op_q, op_d;
    logic [cfg_pkg::K_W-1:0]     k_q, k_d;
    logic [cfg_pkg::V_W-1:0]     v_q, v_d;
    logic [cfg_pkg::H_W-1:0]     h_q, h_d;
    logic                        done_q;

    logic has_k, has_v, has_hash;
    logic req_ok, slot_free, issue, accept;

    h_bdy_fe_dec u_dec (
        .op_i       (i_q_op_dat),
        .has_k_o    (has_k),
        .has_v_o    (has_v),
        .has_hash_o (has_hash)
    );

    assign req_ok = !i_q_op_empty
                  && (!has_k    || !i_q_k_empty)
                  && (!has_v    || !i_q_v_empty)
                  && (!has_hash || !i_q_h_empty);
    assign slot_free = !vld_q || i_bdy_rdy;
    assign issue     = req_ok && slot_free;
    assign accept    = i_cmd_vld_w && o_cmd_rdy_w;

    assign o_q_op_pop = issue;
    assign o_q_k_pop  = issue && has_k;
    assign o_q_v_pop  = issue && has_v;
    assign o_q_h_pop  = issue && has_hash;

    // Ready depends only on registered state so the command pipe never sees a comb loop.
    always_comb begin
        state_d     = state_q;
        o_cmd_rdy_w = (state_q == ST_RUN) && (cnt_q < N_C);
        case (state_q)
            ST_RUN:   if (i_flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0 && !vld_q) state_d = ST_DONE;
            ST_DONE:  if (!i_flush_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !issue && cnt_q != N_C)
            cnt_d = cnt_q + CNT_W'(1);
        else if (!accept && issue && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Operands the opcode does not use are loaded as zero, not as whatever sits at the queue head.
    always_comb begin
        vld_d = vld_q && !i_bdy_rdy;
        op_d  = op_q;
        k_d   = k_q;
        v_d   = v_q;
        h_d   = h_q;
        if (issue) begin
            vld_d = 1'b1;
            op_d  = i_q_op_dat;
            k_d   = has_k    ? i_q_k_dat : '0;
            v_d   = has_v    ? i_q_v_dat : '0;
            h_d   = has_hash ? i_q_h_dat : '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            op_q    <= '0;
            k_q     <= '0;
            v_q     <= '0;
            h_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            op_q    <= op_d;
            k_q     <= k_d;
            v_q     <= v_d;
            h_q     <= h_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign o_bdy_vld_r    = vld_q;
    assign o_bdy_opcode_r = op_q;
    assign o_bdy_k_r      = k_q;
    assign o_bdy_v_r      = v_q;
    assign o_bdy_h_r      = h_q;
    assign o_flush_done_r = done_q;

`ifdef H_BDY_FE_SCHED_CHECK_EN
    logic       stall_w, err_set, err_q;
    logic [1:0] stall_q, stall_d;

    assign stall_w = !i_q_op_empty
                   && ((has_k && i_q_k_empty) || (has_v && i_q_v_empty) || (has_hash && i_q_h_empty));
    assign stall_d = !stall_w ? 2'd0 : (stall_q == 2'd3 ? 2'd3 : stall_q + 2'd1);
    // stall_q holds the previous consecutive stall cycles; a third one in a row is the error.
    assign err_set = (stall_w && stall_q == 2'd2)
                   || (accept && cnt_q == N_C)
                   || (issue && cnt_q == '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_q <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign o_err_r = err_q;

    a_operand_lag: assert property (@(posedge clk) disable iff (!arst_n) !(stall_w && stall_q == 2'd2))
        else $error("operand queue lag beyond 2 cycles");
    a_credit_over: assert property (@(posedge clk) disable iff (!arst_n) !(accept && cnt_q == N_C))
        else $error("accept with credit pool exhausted");
    a_credit_under: assert property (@(posedge clk) disable iff (!arst_n) !(issue && cnt_q == '0))
        else $error("opcode pop with zero credits outstanding");
`endif
endmodule

// File: tb/tb_h_bdy_fe_sched.sv
// tb/tb_h_bdy_fe_sched.sv - directed self-checking bench for h_bdy_fe_sched with modelled command queues

module tb_h_bdy_fe_sched;
    localparam int KW = cfg_pkg::K_W;
    localparam int VW = cfg_pkg::V_W;
    localparam int HW = cfg_pkg::H_W;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          i_cmd_vld_w, o_cmd_rdy_w;
    logic          i_q_op_empty, o_q_op_pop;
    logic [3:0]    i_q_op_dat;
    logic          i_q_k_empty, o_q_k_pop;
    logic [KW-1:0] i_q_k_dat;
    logic          i_q_v_empty, o_q_v_pop;
    logic [VW-1:0] i_q_v_dat;
    logic          i_q_h_empty, o_q_h_pop;
    logic [HW-1:0] i_q_h_dat;
    logic          o_bdy_vld_r;
    logic [3:0]    o_bdy_opcode_r;
    logic [KW-1:0] o_bdy_k_r;
    logic [VW-1:0] o_bdy_v_r;
    logic [HW-1:0] o_bdy_h_r;
    logic          i_bdy_rdy, i_flush_req, o_flush_done_r;
`ifdef H_BDY_FE_SCHED_CHECK_EN
    logic          o_err_r;
`endif

    always #5 clk = ~clk;

    h_bdy_fe_sched dut (
        .clk(clk), .arst_n(arst_n),
        .i_cmd_vld_w(i_cmd_vld_w), .o_cmd_rdy_w(o_cmd_rdy_w),
        .i_q_op_empty(i_q_op_empty), .i_q_op_dat(i_q_op_dat), .o_q_op_pop(o_q_op_pop),
        .i_q_k_empty(i_q_k_empty), .i_q_k_dat(i_q_k_dat), .o_q_k_pop(o_q_k_pop),
        .i_q_v_empty(i_q_v_empty), .i_q_v_dat(i_q_v_dat), .o_q_v_pop(o_q_v_pop),
        .i_q_h_empty(i_q_h_empty), .i_q_h_dat(i_q_h_dat), .o_q_h_pop(o_q_h_pop),
        .o_bdy_vld_r(o_bdy_vld_r), .o_bdy_opcode_r(o_bdy_opcode_r),
        .o_bdy_k_r(o_bdy_k_r), .o_bdy_v_r(o_bdy_v_r), .o_bdy_h_r(o_bdy_h_r),
        .i_bdy_rdy(i_bdy_rdy), .i_flush_req(i_flush_req),
`ifdef H_BDY_FE_SCHED_CHECK_EN
        .o_err_r(o_err_r),
`endif
        .o_flush_done_r(o_flush_done_r)
    );

    typedef struct packed {
        logic [3:0]    op;
        logic [KW-1:0] k;
        logic [VW-1:0] v;
        logic [HW-1:0] h;
    } cmd_t;

    logic [3:0]    qop[$];
    logic [KW-1:0] qk[$];
    logic [VW-1:0] qv[$];
    logic [HW-1:0] qh[$];
    cmd_t          sb[$];

    int n_vec = 0, n_err = 0;
    int seq = 0, cyc = 0, n_issued = 0, first_iss = -1, last_iss = -1;
    logic [3:0]    cur_op;
    logic [KW-1:0] cur_k, pend_k;
    logic [VW-1:0] cur_v;
    logic [HW-1:0] cur_h;
    logic lag_k = 1'b0, pend_k_v = 1'b0;
    logic s_acc, s_rdy, s_pop_op, s_pop_k, s_pop_v, s_pop_h;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operand needs per opcode, as {has_k, has_v, has_hash}.
    function automatic logic [2:0] req_of(input logic [3:0] op);
        case (op)
            4'h1: return 3'b101;
            4'h2: return 3'b111;
            4'h3: return 3'b101;
            4'h4: return 3'b100;
            4'h5: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic drive_q();
        i_q_op_empty = (qop.size() == 0);
        i_q_k_empty  = (qk.size() == 0);
        i_q_v_empty  = (qv.size() == 0);
        i_q_h_empty  = (qh.size() == 0);
        i_q_op_dat   = (qop.size() != 0) ? qop[0] : '0;
        i_q_k_dat    = (qk.size()  != 0) ? qk[0]  : '0;
        i_q_v_dat    = (qv.size()  != 0) ? qv[0]  : '0;
        i_q_h_dat    = (qh.size()  != 0) ? qh[0]  : '0;
    endtask

    task automatic set_cmd(input logic [3:0] op);
        seq++;
        cur_op = op;
        cur_k  = KW'(16'h1000 + seq);
        cur_v  = VW'(32'hA000_0000 + seq);
        cur_h  = HW'(8'h40 + seq);
        i_cmd_vld_w = 1'b1;
    endtask

    task automatic step();
        logic [2:0] r;
        @(negedge clk);
        s_acc = i_cmd_vld_w & o_cmd_rdy_w;
        s_rdy = o_cmd_rdy_w;
        s_pop_op = o_q_op_pop; s_pop_k = o_q_k_pop; s_pop_v = o_q_v_pop; s_pop_h = o_q_h_pop;
        if (o_bdy_vld_r) begin
            if (sb.size() == 0) chk("sb_underrun", 64'(sb.size()), 64'd1);
            else begin
                chk("slot_op", 64'(o_bdy_opcode_r), 64'(sb[0].op));
                chk("slot_k",  64'(o_bdy_k_r),      64'(sb[0].k));
                chk("slot_v",  64'(o_bdy_v_r),      64'(sb[0].v));
                chk("slot_h",  64'(o_bdy_h_r),      64'(sb[0].h));
                if (i_bdy_rdy) begin
                    void'(sb.pop_front());
                    n_issued++;
                    if (first_iss < 0) first_iss = cyc;
                    last_iss = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_pop_op && qop.size() != 0) void'(qop.pop_front());
        if (s_pop_k  && qk.size()  != 0) void'(qk.pop_front());
        if (s_pop_v  && qv.size()  != 0) void'(qv.pop_front());
        if (s_pop_h  && qh.size()  != 0) void'(qh.pop_front());
        if (pend_k_v) begin qk.push_back(pend_k); pend_k_v = 1'b0; end
        if (s_acc) begin
            r = req_of(cur_op);
            qop.push_back(cur_op);
            if (r[2]) begin
                if (lag_k) begin pend_k = cur_k; pend_k_v = 1'b1; end
                else qk.push_back(cur_k);
            end
            if (r[1]) qv.push_back(cur_v);
            if (r[0]) qh.push_back(cur_h);
            sb.push_back('{cur_op, r[2] ? cur_k : '0, r[1] ? cur_v : '0, r[0] ? cur_h : '0});
        end
        drive_q();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        i_bdy_rdy = 1'b1;
        while ((sb.size() != 0 || o_bdy_vld_r) && k < 40) begin step(); k++; end
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
        chk({tag, "_cnt0"}, 64'(dut.cnt_q), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc_n;
        arst_n = 1'b0; i_cmd_vld_w = 1'b0; i_bdy_rdy = 1'b0; i_flush_req = 1'b0;
        cur_op = '0; cur_k = '0; cur_v = '0; cur_h = '0; pend_k = '0;
        drive_q();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld",  64'(o_bdy_vld_r), 64'd0);
        chk("rst_op",   64'(o_bdy_opcode_r), 64'd0);
        chk("rst_k",    64'(o_bdy_k_r), 64'd0);
        chk("rst_v",    64'(o_bdy_v_r), 64'd0);
        chk("rst_h",    64'(o_bdy_h_r), 64'd0);
        chk("rst_done", 64'(o_flush_done_r), 64'd0);
        chk("rst_pop",  64'({o_q_op_pop, o_q_k_pop, o_q_v_pop, o_q_h_pop}), 64'd0);
        chk("rst_rdy",  64'(o_cmd_rdy_w), 64'd1);
        chk("rst_cnt",  64'(dut.cnt_q), 64'd0);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // 8 back-to-back PUTs with the back-end always ready
        i_bdy_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_cmd(4'h2);
            step();
            chk("t1_rdy", 64'(s_rdy), 64'd1);
            chk("t1_acc", 64'(s_acc), 64'd1);
        end
        i_cmd_vld_w = 1'b0;
        drain("t1");
        chk("t1_issued", 64'(n_issued), 64'd8);
        chk("t1_consecutive", 64'(last_iss - first_iss), 64'd7);

        // Slot held by one GET, then credits fill with 8 of 10 offered
        i_bdy_rdy = 1'b0;
        set_cmd(4'h1); step(); i_cmd_vld_w = 1'b0; step();
        chk("t2_slot_full", 64'(o_bdy_vld_r), 64'd1);
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            set_cmd(4'h2); step();
            acc_n += int'(s_acc);
        end
        i_cmd_vld_w = 1'b0;
        chk("t2_accepted", 64'(acc_n), 64'd8);
        chk("t2_rdy_lo", 64'(o_cmd_rdy_w), 64'd0);
        chk("t2_cnt_full", 64'(dut.cnt_q), 64'd8);
        i_bdy_rdy = 1'b1;
        step();
        chk("t2_first_pop", 64'(s_pop_op), 64'd1);
        chk("t2_rdy_at_pop", 64'(s_rdy), 64'd0);
        chk("t2_rdy_back", 64'(o_cmd_rdy_w), 64'd1);
        drain("t2");

        // GET: key and hash popped, value untouched and issued as zero
        set_cmd(4'h1); step(); i_cmd_vld_w = 1'b0; step();
        chk("t3_pop_op", 64'(s_pop_op), 64'd1);
        chk("t3_pop_k",  64'(s_pop_k), 64'd1);
        chk("t3_pop_v",  64'(s_pop_v), 64'd0);
        chk("t3_pop_h",  64'(s_pop_h), 64'd1);
        chk("t3_v_zero", 64'(o_bdy_v_r), 64'd0);
        chk("t3_k_val",  64'(o_bdy_k_r), 64'(cur_k));
        drain("t3");

        // Key arrives one cycle behind its opcode
        set_cmd(4'h1); lag_k = 1'b1; step(); i_cmd_vld_w = 1'b0; lag_k = 1'b0;
        step();
        chk("t4_stall_nopop", 64'(s_pop_op), 64'd0);
        step();
        chk("t4_late_pop", 64'(s_pop_op), 64'd1);
        chk("t4_late_popk", 64'(s_pop_k), 64'd1);
        drain("t4");
`ifdef H_BDY_FE_SCHED_CHECK_EN
        chk("t4_no_err", 64'(o_err_r), 64'd0);
`endif

        // Flush with 3 commands in flight
        i_bdy_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin set_cmd(4'h3); step(); end
        i_cmd_vld_w = 1'b0;
        i_flush_req = 1'b1;
        step();
        chk("t5_rdy_drain", 64'(o_cmd_rdy_w), 64'd0);
        chk("t5_not_done", 64'(o_flush_done_r), 64'd0);
        i_bdy_rdy = 1'b1;
        begin
            int k = 0;
            while (o_bdy_vld_r && k < 20) begin step(); k++; end
            chk("t5_slot_empty", 64'(o_bdy_vld_r), 64'd0);
        end
        chk("t5_done_early", 64'(o_flush_done_r), 64'd0);
        step();
        chk("t5_done", 64'(o_flush_done_r), 64'd1);
        chk("t5_rdy_done", 64'(o_cmd_rdy_w), 64'd0);
        i_flush_req = 1'b0;
        step();
        chk("t5_done_clr", 64'(o_flush_done_r), 64'd0);
        chk("t5_rdy_run", 64'(o_cmd_rdy_w), 64'd1);

        // Flush request dropped mid-drain still completes the drain
        i_bdy_rdy = 1'b0;
        set_cmd(4'h4); step(); i_cmd_vld_w = 1'b0; step();
        i_flush_req = 1'b1; step();
        i_flush_req = 1'b0; step();
        chk("t5b_hold_drain", 64'(o_cmd_rdy_w), 64'd0);
        i_bdy_rdy = 1'b1; step();
        chk("t5b_not_done", 64'(o_flush_done_r), 64'd0);
        step();
        chk("t5b_done", 64'(o_flush_done_r), 64'd1);
        step();
        chk("t5b_done_clr", 64'(o_flush_done_r), 64'd0);
        chk("t5b_rdy_run", 64'(o_cmd_rdy_w), 64'd1);

        // Reset with the slot full and 5 credits outstanding
        i_bdy_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin set_cmd(4'h5); step(); end
        i_cmd_vld_w = 1'b0;
        chk("t6_cnt5", 64'(dut.cnt_q), 64'd5);
        chk("t6_vld_pre", 64'(o_bdy_vld_r), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        chk("t6_vld_clr", 64'(o_bdy_vld_r), 64'd0);
        chk("t6_cnt_clr", 64'(dut.cnt_q), 64'd0);
        chk("t6_state_run", 64'(dut.state_q), 64'd0);
        chk("t6_rdy", 64'(o_cmd_rdy_w), 64'd1);
        qop.delete(); qk.delete(); qv.delete(); qh.delete(); sb.delete();
        pend_k_v = 1'b0;
        drive_q();
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk); #1;
        set_cmd(4'h2); step(); i_cmd_vld_w = 1'b0;
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
